// File: rtl/reg_file_seq.sv
// Command sequencer that owns the register file ports: clears every register after
// reset, then executes one ALU/LDI/RD command at a time with write-back.
module reg_file_seq #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rd,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rs2,
  input  logic [REG_WIDTH-1:0]  i_cmd_imm,
  output logic [ADDR_WIDTH-1:0] o_reg_a_addr_r,
  output logic [ADDR_WIDTH-1:0] o_reg_b_addr_r,
  input  logic [REG_WIDTH-1:0]  i_reg_a_val_r,
  input  logic [REG_WIDTH-1:0]  i_reg_b_val_r,
  output logic [ADDR_WIDTH-1:0] o_reg_addr_w,
  output logic [REG_WIDTH-1:0]  o_reg_val_w,
  output logic                  o_write_en,
  output logic                  o_done,
  output logic [REG_WIDTH-1:0]  o_result,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [2:0] ST_RST_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_READ     = 3'd3;
  localparam logic [2:0] ST_WB       = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_RD   = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d;
  logic [REG_WIDTH-1:0]  res_q, res_d;
  logic [REG_WIDTH-1:0]  alu_res;
  logic                  wb_write;

  always_comb begin
    alu_res = i_reg_a_val_r;
    case (op_q)
      OP_ADD:  alu_res = i_reg_a_val_r + i_reg_b_val_r;
      OP_SUB:  alu_res = i_reg_a_val_r - i_reg_b_val_r;
      OP_AND:  alu_res = i_reg_a_val_r & i_reg_b_val_r;
      OP_OR:   alu_res = i_reg_a_val_r | i_reg_b_val_r;
      OP_XOR:  alu_res = i_reg_a_val_r ^ i_reg_b_val_r;
      OP_SLTU: alu_res = {{(REG_WIDTH-1){1'b0}}, (i_reg_a_val_r < i_reg_b_val_r)};
      default: alu_res = i_reg_a_val_r;
    endcase
  end

  // Handshake: a command transfers on a rising edge where i_cmd_valid and
  // o_cmd_ready are both high; fields are sampled only on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    case (state_q)
      ST_RST_WAIT: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_cmd_valid) begin
          op_d = i_cmd_op;
          rd_d = i_cmd_rd;
          if (i_cmd_op == OP_LDI) begin
            res_d   = i_cmd_imm;
            state_d = ST_WB;
          end else begin
            ra_d    = i_cmd_rs1;
            rb_d    = i_cmd_rs2;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        res_d   = alu_res;
        state_d = ST_WB;
      end
      ST_WB: state_d = ST_IDLE;
      default: state_d = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RST_WAIT;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
    end
  end

  // Write port is decoded from state so a reset mid-WB drops the write at once.
  assign wb_write       = (state_q == ST_WB) && (op_q != OP_RD);
  assign o_write_en     = (state_q == ST_INIT) || wb_write;
  assign o_reg_addr_w   = (state_q == ST_INIT) ? cnt_q : (wb_write ? rd_q : '0);
  assign o_reg_val_w    = wb_write ? res_q : '0;
  assign o_reg_a_addr_r = ra_q;
  assign o_reg_b_addr_r = rb_q;
  assign o_cmd_ready    = (state_q == ST_IDLE);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_WB);
  assign o_result       = res_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Bench for reg_file_seq: behavioural register file, command driver and a
// scoreboard monitor that checks every completion against hand-computed values.
module tb_reg_file_seq;

  localparam int AW = 3;
  localparam int RW = 32;
  localparam int NREGS = 8;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [2:0]    i_cmd_op;
  logic [AW-1:0] i_cmd_rd, i_cmd_rs1, i_cmd_rs2;
  logic [RW-1:0] i_cmd_imm;
  logic [AW-1:0] o_reg_a_addr_r, o_reg_b_addr_r;
  logic [RW-1:0] i_reg_a_val_r, i_reg_b_val_r;
  logic [AW-1:0] o_reg_addr_w;
  logic [RW-1:0] o_reg_val_w;
  logic          o_write_en;
  logic          o_done;
  logic [RW-1:0] o_result;
  logic          o_busy;
  logic [2:0]    o_dbg_state;

  reg_file_seq #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_rd(i_cmd_rd), .i_cmd_rs1(i_cmd_rs1),
    .i_cmd_rs2(i_cmd_rs2), .i_cmd_imm(i_cmd_imm),
    .o_reg_a_addr_r(o_reg_a_addr_r), .o_reg_b_addr_r(o_reg_b_addr_r),
    .i_reg_a_val_r(i_reg_a_val_r), .i_reg_b_val_r(i_reg_b_val_r),
    .o_reg_addr_w(o_reg_addr_w), .o_reg_val_w(o_reg_val_w),
    .o_write_en(o_write_en), .o_done(o_done), .o_result(o_result),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural register file: combinational read, synchronous write
  logic [RW-1:0] mem [NREGS];
  logic          fill;
  always @(posedge i_clk) begin
    if (fill) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= 32'hDEAD_0000 | i;
    end else if (o_write_en) begin
      mem[o_reg_addr_w] <= o_reg_val_w;
    end
  end
  assign i_reg_a_val_r = mem[o_reg_a_addr_r];
  assign i_reg_b_val_r = mem[o_reg_b_addr_r];

  // scoreboard
  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_sent   = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("done_without_command", 32'd1, 32'd0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("result", o_result, e[31:0]);
        chk("wb_write_en", {31'd0, o_write_en}, {31'd0, e[35]});
        chk("wb_addr", {29'd0, o_reg_addr_w}, {29'd0, e[34:32]});
        chk("wb_data", o_reg_val_w, e[35] ? e[31:0] : 32'd0);
      end
    end
  end

  // driver tasks
  task automatic check_reset_values();
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("rst_write_en", {31'd0, o_write_en}, 32'd0);
    chk("rst_addr_a", {29'd0, o_reg_a_addr_r}, 32'd0);
    chk("rst_addr_b", {29'd0, o_reg_b_addr_r}, 32'd0);
    chk("rst_addr_w", {29'd0, o_reg_addr_w}, 32'd0);
    chk("rst_val_w", o_reg_val_w, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd1);
  endtask

  // Called at the negedge where i_rst_n is released.
  task automatic init_sweep();
    #1;
    chk("sweep_c0_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("sweep_c0_we", {31'd0, o_write_en}, 32'd0);
    for (int c = 1; c <= NREGS; c++) begin
      @(negedge i_clk);
      chk("sweep_ready", {31'd0, o_cmd_ready}, 32'd0);
      chk("sweep_we", {31'd0, o_write_en}, 32'd1);
      chk("sweep_addr", {29'd0, o_reg_addr_w}, c - 1);
      chk("sweep_data", o_reg_val_w, 32'd0);
    end
    @(negedge i_clk);
    chk("sweep_ready_rise", {31'd0, o_cmd_ready}, 32'd1);
    chk("sweep_we_end", {31'd0, o_write_en}, 32'd0);
    chk("sweep_busy_end", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < NREGS; i++) chk("sweep_reg_zero", mem[i], 32'd0);
  endtask

  // Entered at a negedge; returns at the negedge of the command's WB cycle.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [31:0] imm, input logic [31:0] exp_res,
                          input bit hold);
    int t;
    logic we;
    t = 0;
    while (!o_cmd_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_cmd_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      i_cmd_valid = 1'b0;
      return;
    end
    we = (op != 3'd7);
    exp_q.push_back({we, we ? rd : 3'd0, exp_res});
    n_sent++;
    i_cmd_valid = 1'b1;
    i_cmd_op = op; i_cmd_rd = rd; i_cmd_rs1 = rs1; i_cmd_rs2 = rs2; i_cmd_imm = imm;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = hold;
    i_cmd_op  = 3'($urandom_range(0, 7));
    i_cmd_rd  = 3'($urandom_range(0, 7));
    i_cmd_rs1 = 3'($urandom_range(0, 7));
    i_cmd_rs2 = 3'($urandom_range(0, 7));
    i_cmd_imm = $urandom;
    if (op == 3'd5) begin
      chk("ldi_latency_done", {31'd0, o_done}, 32'd1);
    end else begin
      chk("alu_read_no_done", {31'd0, o_done}, 32'd0);
      @(negedge i_clk);
      chk("alu_latency_done", {31'd0, o_done}, 32'd1);
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < NREGS; i++) send_cmd(3'd7, 3'd0, 3'(i), 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; fill = 1'b1;
    i_cmd_op = '0; i_cmd_rd = '0; i_cmd_rs1 = '0; i_cmd_rs2 = '0; i_cmd_imm = '0;
    repeat (2) @(posedge i_clk);
    #1 fill = 1'b0;
    check_reset_values();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    init_sweep();
    read_all_zero();

    // wrap-around arithmetic
    send_cmd(3'd5, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send_cmd(3'd5, 3'd2, 3'd0, 3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    send_cmd(3'd0, 3'd3, 3'd1, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    send_cmd(3'd1, 3'd4, 3'd3, 3'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
    // logic ops and unsigned compare
    send_cmd(3'd5, 3'd5, 3'd0, 3'd0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
    send_cmd(3'd5, 3'd6, 3'd0, 3'd0, 32'h00FF_00FF, 32'h00FF_00FF, 1'b0);
    send_cmd(3'd2, 3'd7, 3'd5, 3'd6, 32'd0, 32'h000F_000F, 1'b0);
    send_cmd(3'd4, 3'd7, 3'd5, 3'd6, 32'd0, 32'h0FF0_0FF0, 1'b0);
    send_cmd(3'd3, 3'd3, 3'd5, 3'd6, 32'd0, 32'h0FFF_0FFF, 1'b0);
    send_cmd(3'd6, 3'd0, 3'd5, 3'd6, 32'd0, 32'h0000_0000, 1'b0);
    send_cmd(3'd6, 3'd0, 3'd2, 3'd1, 32'd0, 32'h0000_0001, 1'b0);
    send_cmd(3'd6, 3'd0, 3'd6, 3'd5, 32'd0, 32'h0000_0001, 1'b0);
    // back-to-back hazard, rd == rs, and read-only op
    send_cmd(3'd5, 3'd1, 3'd0, 3'd0, 32'h0000_0005, 32'h0000_0005, 1'b0);
    send_cmd(3'd0, 3'd1, 3'd1, 3'd1, 32'd0, 32'h0000_000A, 1'b0);
    send_cmd(3'd7, 3'd5, 3'd1, 3'd0, 32'd0, 32'h0000_000A, 1'b0);
    send_cmd(3'd1, 3'd2, 3'd2, 3'd1, 32'd0, 32'hFFFF_FFF7, 1'b0);
    send_cmd(3'd7, 3'd0, 3'd2, 3'd0, 32'd0, 32'hFFFF_FFF7, 1'b0);
    // valid held high with changing fields while busy
    send_cmd(3'd5, 3'd3, 3'd0, 3'd0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    send_cmd(3'd0, 3'd4, 3'd3, 3'd3, 32'd0, 32'h2468_ACF0, 1'b1);
    send_cmd(3'd7, 3'd0, 3'd4, 3'd0, 32'd0, 32'h2468_ACF0, 1'b1);
    send_cmd(3'd7, 3'd0, 3'd0, 3'd0, 32'd0, 32'h0000_0001, 1'b1);
    i_cmd_valid = 1'b0;
    chk("model_r4", mem[4], 32'h2468_ACF0);
    chk("model_r1", mem[1], 32'h0000_000A);

    // reset during WB of ADD r2 = r1 + r1 drops the write
    @(negedge i_clk);
    while (!o_cmd_ready) @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_op = 3'd0; i_cmd_rd = 3'd2; i_cmd_rs1 = 3'd1; i_cmd_rs2 = 3'd1;
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("abort_in_wb", {31'd0, o_done}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge i_clk);
    #1;
    chk("abort_r2_kept", mem[2], 32'hFFFF_FFF7);
    fill = 1'b1;
    @(posedge i_clk);
    #1 fill = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    init_sweep();
    read_all_zero();

    repeat (4) @(negedge i_clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", n_done, n_sent);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_seq.md
# reg_file_seq

Command-driven sequencer that owns both ports of the register file: it drives the two combinational read ports and the synchronous write port. After reset it clears every register to zero. It then accepts one ALU command at a time over a valid/ready handshake, fetches operands, computes the result and writes it back to the register file. It sits between the instruction/control source and `reg_file`.

## Interface
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH
- REG_WIDTH, 32, register data width
- i_clk  in  1  clock, all flops on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  sequencer can accept a command
- i_cmd_op  in  3  operation code
- i_cmd_rd / i_cmd_rs1 / i_cmd_rs2  in  ADDR_WIDTH  destination / source A / source B
- i_cmd_imm  in  REG_WIDTH  immediate for LDI
- o_reg_a_addr_r / o_reg_b_addr_r  out  ADDR_WIDTH  register file read addresses
- i_reg_a_val_r / i_reg_b_val_r  in  REG_WIDTH  register file read data (combinational)
- o_reg_addr_w  out  ADDR_WIDTH  write address
- o_reg_val_w  out  REG_WIDTH  write data
- o_write_en  out  1  write strobe; the register file commits on the rising edge that ends the cycle
- o_done  out  1  one-cycle pulse, command complete
- o_result  out  REG_WIDTH  result of the last completed command; held until the next completion
- o_busy  out  1  high in every state except IDLE

## Operation
- Ops: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 LDI rd=imm (no read), 6 SLTU rd=(a<b unsigned)?1:0, 7 RD (result=a, no write).
- a = reg[rs1], b = reg[rs2]. ADD and SUB wrap modulo 2**REG_WIDTH; there is no carry or flag output.
- States and transitions:
  - RST_WAIT: reset value. Always moves to INIT.
  - INIT: write 0 to reg[cnt], cnt incrementing from 0 to NUM_REGS-1. After the last register, moves to IDLE.
  - IDLE: o_cmd_ready=1. Handshake to READ, or to WB if op=LDI.
  - READ: read addresses are driven from the captured rs1/rs2. Operands are latched at the end of the cycle. Moves to WB.
  - WB: o_write_en=1 (0 for RD), o_reg_addr_w=rd, o_reg_val_w=result, o_done=1, o_result updated. Moves to IDLE.
- The command (op, rd, rs1, rs2, imm) is captured on the handshake edge. Inputs are don't-care afterwards.
- Read addresses hold their last value outside READ.
- o_reg_val_w and o_reg_addr_w are 0 whenever o_write_en=0.

## Timing
- All outputs are registered or decoded directly from state.
- Reset values: o_cmd_ready 0, o_write_en 0, all addresses 0, o_reg_val_w 0, o_done 0, o_result 0, o_busy 1.
- After i_rst_n deassert:
  - Edge 1 enters INIT.
  - INIT writes occupy cycles 1..NUM_REGS.
  - o_cmd_ready rises in cycle NUM_REGS+1.
- Handshake: accepted on an edge where i_cmd_valid and o_cmd_ready are both 1. o_cmd_ready falls the next cycle. A valid held while ready=0 is neither lost nor duplicated.
- Latency and throughput:
  - ALU/RD ops: handshake at edge N, READ in cycle N..N+1, WB in cycle N+1..N+2, o_done high in that WB cycle, IDLE at N+2. One command per 3 cycles.
  - LDI: WB directly after the handshake. One command per 2 cycles.
- rd equal to rs1 or rs2: the old value is read, because the write commits after READ.
- Back-to-back commands: a command reading the previous rd sees the new value, because the write commits at the end of WB before the next READ.
- Reset asserted mid-INIT or mid-command:
  - All outputs return to reset values immediately.
  - The pending write is dropped, with no partial write.
  - The full INIT sweep reruns after release.

## Test plan
- Reset release: o_cmd_ready=0 for NUM_REGS+1 cycles, o_write_en high for exactly 8 cycles with addresses 0..7 and data 0 -> every register reads 0, then o_cmd_ready=1.
- LDI r1=0xFFFF_FFFF, LDI r2=1, ADD r3=r1+r2 -> r3=0, o_done pulses once per command, o_result=0. Then SUB r4=r3-r2 -> 0xFFFF_FFFF.
- LDI r5=0x0F0F_0F0F, LDI r6=0x00FF_00FF:
  - AND r7 -> 0x000F_000F.
  - XOR r7 -> 0x0FF0_0FF0.
  - SLTU r0=r6<r5 -> 1.
- Hazard: LDI r1=5, then immediately ADD r1=r1+r1 -> r1=10. RD r1 -> o_result=10 with o_write_en=0.
- Backpressure: hold i_cmd_valid=1 with changing fields while busy -> exactly one command per handshake, fields sampled only at the handshake edge.
- Assert i_rst_n=0 during the WB cycle of ADD r2 -> r2 is not updated, then INIT reruns and all registers read 0.
